// File: rtl/s100_hold_pkg.sv
// Shared types and defaults for the S-100 bus-hold sequencer.
// Imported by the hold controller and its testbench.
package s100_hold_pkg;

    localparam int CNT_W       = 16;
    localparam int SETTLE_DEF  = 2;
    localparam int TIMEOUT_DEF = 1024;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_REQ     = 3'd1;
    localparam logic [2:0] ST_DISABLE = 3'd2;
    localparam logic [2:0] ST_GRANT   = 3'd3;
    localparam logic [2:0] ST_UNGRANT = 3'd4;
    localparam logic [2:0] ST_RELEASE = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_REQ     = ST_REQ,
        S_DISABLE = ST_DISABLE,
        S_GRANT   = ST_GRANT,
        S_UNGRANT = ST_UNGRANT,
        S_RELEASE = ST_RELEASE
    } hold_state_t;

    typedef struct packed {
        logic busrq_n;
        logic mux_select;
        logic phlda;
        logic active;
    } hold_out_t;

    function automatic hold_out_t decode_out(hold_state_t s);
        hold_out_t o;
        o.busrq_n    = !(s inside {S_REQ, S_DISABLE, S_GRANT, S_UNGRANT});
        o.mux_select = s inside {S_DISABLE, S_GRANT, S_UNGRANT};
        o.phlda      = (s == S_GRANT);
        o.active     = (s != S_IDLE);
        return o;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous S-100 inputs.
// Both flops clear to 0 on reset.
module sync_2ff (
    input  logic clock,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/s100_hold_ctl.sv
// S-100 HOLD*/pHLDA sequencer: parks the Z80 via BUSRQ/BUSAK and
// blanks the control bus before granting, reversing on release.
module s100_hold_ctl
    import s100_hold_pkg::*;
#(
    parameter int SETTLE_CYCLES  = SETTLE_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
    input  logic clock,
    input  logic reset_n,
    input  logic hold_req_n,
    input  logic cpu_busak_n,
    input  logic err_clr,
    output logic cpu_busrq_n,
    output logic mux_select,
    output logic phlda,
    output logic hold_active,
    output logic timeout_err
);

    localparam logic [CNT_W-1:0] SETTLE   = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic             hold_req;
    logic             hold_sync;
    logic             lockout;
    logic [CNT_W-1:0] cnt;
    hold_state_t      state;
    hold_out_t        outs;

    assign hold_req = ~hold_req_n;

    sync_2ff u_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (hold_req),
        .q       (hold_sync)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            outs        <= decode_out(S_IDLE);
            cnt         <= '0;
            lockout     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (err_clr)
                timeout_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!hold_sync)
                        lockout <= 1'b0;
                    if (hold_sync && !lockout) begin
                        state <= S_REQ;
                        outs  <= decode_out(S_REQ);
                        cnt   <= '0;
                    end
                end
                S_REQ: begin
                    if (!hold_sync) begin
                        state <= S_RELEASE;
                        outs  <= decode_out(S_RELEASE);
                    end else if (!cpu_busak_n) begin
                        state <= S_DISABLE;
                        outs  <= decode_out(S_DISABLE);
                        cnt   <= SETTLE;
                    end else if (cnt == TMO_LAST) begin
                        // set after the err_clr above so a same-cycle set wins
                        state       <= S_RELEASE;
                        outs        <= decode_out(S_RELEASE);
                        timeout_err <= 1'b1;
                        lockout     <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DISABLE: begin
                    if (!hold_sync) begin
                        state <= S_UNGRANT;
                        outs  <= decode_out(S_UNGRANT);
                        cnt   <= SETTLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                        if (cnt <= CNT_W'(1)) begin
                            state       <= S_GRANT;
                            outs        <= decode_out(S_GRANT);
                            timeout_err <= 1'b0;
                        end
                    end
                end
                S_GRANT: begin
                    if (!hold_sync) begin
                        state <= S_UNGRANT;
                        outs  <= decode_out(S_UNGRANT);
                        cnt   <= SETTLE;
                    end
                end
                S_UNGRANT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt <= CNT_W'(1)) begin
                        state <= S_RELEASE;
                        outs  <= decode_out(S_RELEASE);
                    end
                end
                S_RELEASE: begin
                    if (cpu_busak_n) begin
                        state <= S_IDLE;
                        outs  <= decode_out(S_IDLE);
                    end
                end
                default: begin
                    state <= S_RELEASE;
                    outs  <= decode_out(S_RELEASE);
                end
            endcase
        end
    end

    assign cpu_busrq_n = outs.busrq_n;
    assign mux_select  = outs.mux_select;
    assign phlda       = outs.phlda;
    assign hold_active = outs.active;

endmodule

// File: tb/tb_s100_hold_ctl.sv
// Scoreboard bench for s100_hold_ctl with SETTLE=2, TIMEOUT=16.
// Vectors are {busrq_n, mux_select, phlda, hold_active, timeout_err}.
module tb_s100_hold_ctl;

    localparam logic [4:0] V_IDLE = 5'b10000;
    localparam logic [4:0] V_REQ  = 5'b00010;
    localparam logic [4:0] V_DIS  = 5'b01010;
    localparam logic [4:0] V_GNT  = 5'b01110;
    localparam logic [4:0] V_UNG  = 5'b01010;
    localparam logic [4:0] V_REL  = 5'b10010;
    localparam logic [4:0] V_ERR  = 5'b00001;

    typedef struct {
        string      tag;
        int         cyc;
        logic [4:0] v;
    } exp_t;

    logic clock;
    logic reset_n;
    logic hold_req_n;
    logic cpu_busak_n;
    logic err_clr;
    logic cpu_busrq_n;
    logic mux_select;
    logic phlda;
    logic hold_active;
    logic timeout_err;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    bit   inv_en = 1'b0;
    logic p_phlda = 1'b0;
    logic p_mux = 1'b0;
    exp_t sb[$];

    s100_hold_ctl #(
        .SETTLE_CYCLES  (2),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .hold_req_n  (hold_req_n),
        .cpu_busak_n (cpu_busak_n),
        .err_clr     (err_clr),
        .cpu_busrq_n (cpu_busrq_n),
        .mux_select  (mux_select),
        .phlda       (phlda),
        .hold_active (hold_active),
        .timeout_err (timeout_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    function automatic logic [4:0] obs();
        return {cpu_busrq_n, mux_select, phlda, hold_active, timeout_err};
    endfunction

    task automatic chk(string tag, logic [7:0] got, logic [7:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%b want=%b", tag, cyc, got, want);
        end
    endtask

    task automatic expect_at(string tag, int c, logic [4:0] v);
        exp_t e;
        int   i;
        e.tag = tag;
        e.cyc = c;
        e.v   = v;
        i = 0;
        while (i < sb.size() && sb[i].cyc <= c)
            i++;
        sb.insert(i, e);
    endtask

    task automatic wait_cyc(int c);
        while (cyc < c)
            @(negedge clock);
    endtask

    always @(negedge clock) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            chk(e.tag, 8'(obs()), 8'(e.v));
        end
        if (inv_en) begin
            chk("inv_phlda_bus",
                8'(phlda && !(mux_select && !cpu_busrq_n)), 8'd0);
            chk("inv_same_edge",
                8'((phlda != p_phlda) && (mux_select != p_mux)), 8'd0);
        end
        p_phlda = phlda;
        p_mux   = mux_select;
    end

    initial begin
        int c;
        int d;
        reset_n     = 1'b1;
        hold_req_n  = 1'b1;
        cpu_busak_n = 1'b1;
        err_clr     = 1'b0;
        #1 reset_n = 1'b0;
        #1 chk("reset_outs", 8'(obs()), 8'(V_IDLE));
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        wait_cyc(cyc + 1);
        inv_en = 1'b1;

        // normal handoff
        c = cyc;
        expect_at("s1_busrq_pre",  c + 2,  V_IDLE);
        expect_at("s1_busrq_fall", c + 3,  V_REQ);
        expect_at("s1_req_hold",   c + 7,  V_REQ);
        expect_at("s1_mux_rise",   c + 8,  V_DIS);
        expect_at("s1_phlda_pre",  c + 9,  V_DIS);
        expect_at("s1_phlda_rise", c + 10, V_GNT);
        expect_at("s1_grant_hold", c + 22, V_GNT);
        expect_at("s1_phlda_fall", c + 23, V_UNG);
        expect_at("s1_mux_pre",    c + 24, V_UNG);
        expect_at("s1_mux_fall",   c + 25, V_REL);
        expect_at("s1_rel_wait",   c + 27, V_REL);
        expect_at("s1_idle",       c + 28, V_IDLE);
        hold_req_n = 1'b0;
        wait_cyc(c + 7);
        cpu_busak_n = 1'b0;
        wait_cyc(c + 20);
        hold_req_n = 1'b1;
        wait_cyc(c + 27);
        cpu_busak_n = 1'b1;
        wait_cyc(c + 31);

        // withdrawn before BUSAK
        c = cyc;
        expect_at("s2_req",     c + 3, V_REQ);
        expect_at("s2_req_mid", c + 5, V_REQ);
        expect_at("s2_req_end", c + 6, V_REQ);
        expect_at("s2_release", c + 7, V_REL);
        expect_at("s2_idle",    c + 8, V_IDLE);
        hold_req_n = 1'b0;
        wait_cyc(c + 4);
        hold_req_n = 1'b1;
        wait_cyc(c + 11);

        // timeout, lockout, retry, err_clr
        c = cyc;
        expect_at("s3_req",         c + 3,  V_REQ);
        expect_at("s3_req_last",    c + 18, V_REQ);
        expect_at("s3_timeout",     c + 19, V_REL | V_ERR);
        expect_at("s3_idle_err",    c + 20, V_IDLE | V_ERR);
        expect_at("s3_lockout",     c + 30, V_IDLE | V_ERR);
        expect_at("s3_retry_pre",   c + 36, V_IDLE | V_ERR);
        expect_at("s3_retry",       c + 37, V_REQ | V_ERR);
        expect_at("s3_clr_pre",     c + 38, V_REQ | V_ERR);
        expect_at("s3_err_clr",     c + 39, V_REQ);
        expect_at("s3_withdraw",    c + 43, V_REL);
        expect_at("s3_idle",        c + 44, V_IDLE);
        hold_req_n = 1'b0;
        wait_cyc(c + 30);
        hold_req_n = 1'b1;
        wait_cyc(c + 34);
        hold_req_n = 1'b0;
        wait_cyc(c + 38);
        err_clr = 1'b1;
        wait_cyc(c + 39);
        err_clr = 1'b0;
        wait_cyc(c + 40);
        hold_req_n = 1'b1;
        wait_cyc(c + 47);

        // withdrawal during DISABLE
        c = cyc;
        expect_at("s4_req",      c + 4,  V_REQ);
        expect_at("s4_disable",  c + 5,  V_DIS);
        expect_at("s4_ungrant",  c + 6,  V_UNG);
        expect_at("s4_no_phlda", c + 7,  V_UNG);
        expect_at("s4_mux_fall", c + 8,  V_REL);
        expect_at("s4_idle",     c + 10, V_IDLE);
        hold_req_n = 1'b0;
        wait_cyc(c + 3);
        hold_req_n = 1'b1;
        wait_cyc(c + 4);
        cpu_busak_n = 1'b0;
        wait_cyc(c + 9);
        cpu_busak_n = 1'b1;
        wait_cyc(c + 12);

        // asynchronous reset while granted
        c = cyc;
        expect_at("s5_req",     c + 3, V_REQ);
        expect_at("s5_disable", c + 4, V_DIS);
        expect_at("s5_grant",   c + 6, V_GNT);
        expect_at("s5_grant2",  c + 7, V_GNT);
        hold_req_n = 1'b0;
        wait_cyc(c + 3);
        cpu_busak_n = 1'b0;
        wait_cyc(c + 8);
        #3;
        inv_en  = 1'b0;
        reset_n = 1'b0;
        #1 chk("s5_async_reset", 8'(obs()), 8'(V_IDLE));
        cpu_busak_n = 1'b1;
        @(negedge clock);
        reset_n = 1'b1;
        d = cyc;
        expect_at("s5_reacq_pre", d + 2, V_IDLE);
        expect_at("s5_reacq",     d + 3, V_REQ);
        expect_at("s5_req_hold",  d + 5, V_REQ);
        expect_at("s5_release",   d + 6, V_REL);
        expect_at("s5_idle",      d + 7, V_IDLE);
        wait_cyc(d + 1);
        inv_en = 1'b1;
        wait_cyc(d + 3);
        hold_req_n = 1'b1;
        wait_cyc(d + 10);

        // random HOLD*/BUSAK for invariant coverage
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(7) == 0)
                hold_req_n = ~hold_req_n;
            if ($urandom_range(3) == 0)
                cpu_busak_n = cpu_busrq_n;
            err_clr = ($urandom_range(15) == 0);
            wait_cyc(cyc + 1);
        end
        hold_req_n  = 1'b1;
        cpu_busak_n = 1'b1;
        err_clr     = 1'b0;
        wait_cyc(cyc + 8);

        chk("sb_drain", 8'(sb.size()), 8'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
